// File: rtl/vga_screen_mux.sv
// vga_screen_mux: frame-synchronous selector between the game and end-screen VGA sources,
// inserting black frames on game-over and pulsing a game restart on return to play.
`timescale 1ns/1ps
module vga_screen_mux #(
  parameter int BLANK_FRAMES = 2
) (
  input  logic       Clk_40mhz,
  input  logic       RST,
  input  logic       game_over,
  input  logic       restart,
  input  logic       game_Hsync_sig,
  input  logic       game_Vsync_sig,
  input  logic [4:0] game_Vga_red,
  input  logic [5:0] game_Vga_green,
  input  logic [4:0] game_Vga_blue,
  input  logic       end_Hsync_sig,
  input  logic       end_Vsync_sig,
  input  logic [4:0] end_Vga_red,
  input  logic [5:0] end_Vga_green,
  input  logic [4:0] end_Vga_blue,
  output logic       Hsync_sig,
  output logic       Vsync_sig,
  output logic [4:0] Vga_red,
  output logic [5:0] Vga_green,
  output logic [4:0] Vga_blue,
  output logic       end_active,
  output logic       game_reset
);
  typedef enum logic [2:0] {S_GAME, S_TO_END, S_BLANK, S_END, S_TO_GAME} state_t;
  localparam logic [3:0] LAST = (BLANK_FRAMES == 0) ? 4'd0 : 4'(BLANK_FRAMES - 1);
  state_t r_state, w_next;
  logic [3:0] r_blank_cnt, w_blank_cnt;
  logic r_g_vs, r_e_vs, w_g_vs_fall, w_e_vs_fall, w_pulse, w_sel_end, w_black;
  assign w_g_vs_fall = r_g_vs & ~game_Vsync_sig;
  assign w_e_vs_fall = r_e_vs & ~end_Vsync_sig;
  assign w_sel_end = (r_state == S_BLANK) || (r_state == S_END) || (r_state == S_TO_GAME);
  assign w_black = r_state == S_BLANK;
  assign end_active = r_state == S_END;
  always_comb begin
    w_next = r_state;
    w_blank_cnt = r_blank_cnt;
    w_pulse = 1'b0;
    case (r_state)
      S_GAME: if (game_over) w_next = S_TO_END;
      S_TO_END: if (w_g_vs_fall) begin
        w_next = (BLANK_FRAMES == 0) ? S_END : S_BLANK;
        w_blank_cnt = 4'd0;
      end
      S_BLANK: if (w_e_vs_fall) begin
        if (r_blank_cnt == LAST) w_next = S_END;
        w_blank_cnt = (r_blank_cnt == 4'hF) ? r_blank_cnt : r_blank_cnt + 4'd1;
      end
      S_END: if (restart) w_next = S_TO_GAME;
      S_TO_GAME: if (w_e_vs_fall) begin
        w_next = S_GAME;
        w_pulse = 1'b1;
      end
      default: w_next = S_GAME;
    endcase
  end
  always_ff @(posedge Clk_40mhz or posedge RST) begin
    if (RST) begin
      r_state <= S_GAME;
      r_blank_cnt <= 4'd0;
      r_g_vs <= 1'b1;
      r_e_vs <= 1'b1;
      game_reset <= 1'b0;
      Hsync_sig <= 1'b1;
      Vsync_sig <= 1'b1;
      Vga_red <= 5'd0;
      Vga_green <= 6'd0;
      Vga_blue <= 5'd0;
    end else begin
      r_state <= w_next;
      r_blank_cnt <= w_blank_cnt;
      r_g_vs <= game_Vsync_sig;
      r_e_vs <= end_Vsync_sig;
      game_reset <= w_pulse;
      Hsync_sig <= w_sel_end ? end_Hsync_sig : game_Hsync_sig;
      Vsync_sig <= w_sel_end ? end_Vsync_sig : game_Vsync_sig;
      Vga_red <= w_black ? 5'd0 : w_sel_end ? end_Vga_red : game_Vga_red;
      Vga_green <= w_black ? 6'd0 : w_sel_end ? end_Vga_green : game_Vga_green;
      Vga_blue <= w_black ? 5'd0 : w_sel_end ? end_Vga_blue : game_Vga_blue;
    end
  end
endmodule

// File: tb/tb_vga_screen_mux.sv
// tb_vga_screen_mux: directed checks of source switching, black-frame insertion and restart.
`timescale 1ns/1ps
module tb_vga_screen_mux;
  logic clk = 1'b0, rst = 1'b1, game_over = 1'b0, restart = 1'b0;
  logic g_hs = 1'b1, g_vs = 1'b1, e_hs = 1'b0, e_vs = 1'b1;
  logic [4:0] g_r = 5'h1F, g_b = 5'h00, e_r = 5'h00, e_b = 5'h03;
  logic [5:0] g_g = 6'h00, e_g = 6'h00;
  logic hs, vs, ea, gr, hs0, vs0, ea0, gr0;
  logic [4:0] r, b, r0, b0;
  logic [5:0] g, g0;
  logic [17:0] out, out0;
  int n_pass = 0, n_total = 0;
  localparam logic [17:0] RST_V = {2'b11, 16'h0};
  assign out = {hs, vs, r, g, b};
  assign out0 = {hs0, vs0, r0, g0, b0};
  always #5 clk = ~clk;

  vga_screen_mux #(.BLANK_FRAMES(2)) dut (
    .Clk_40mhz(clk), .RST(rst), .game_over(game_over), .restart(restart),
    .game_Hsync_sig(g_hs), .game_Vsync_sig(g_vs), .game_Vga_red(g_r), .game_Vga_green(g_g), .game_Vga_blue(g_b),
    .end_Hsync_sig(e_hs), .end_Vsync_sig(e_vs), .end_Vga_red(e_r), .end_Vga_green(e_g), .end_Vga_blue(e_b),
    .Hsync_sig(hs), .Vsync_sig(vs), .Vga_red(r), .Vga_green(g), .Vga_blue(b),
    .end_active(ea), .game_reset(gr));

  vga_screen_mux #(.BLANK_FRAMES(0)) dut0 (
    .Clk_40mhz(clk), .RST(rst), .game_over(game_over), .restart(restart),
    .game_Hsync_sig(g_hs), .game_Vsync_sig(g_vs), .game_Vga_red(g_r), .game_Vga_green(g_g), .game_Vga_blue(g_b),
    .end_Hsync_sig(e_hs), .end_Vsync_sig(e_vs), .end_Vga_red(e_r), .end_Vga_green(e_g), .end_Vga_blue(e_b),
    .Hsync_sig(hs0), .Vsync_sig(vs0), .Vga_red(r0), .Vga_green(g0), .Vga_blue(b0),
    .end_active(ea0), .game_reset(gr0));

  function automatic logic [17:0] gb(input logic v);
    return {1'b1, v, 5'h1F, 6'h00, 5'h00};
  endfunction
  function automatic logic [17:0] eb(input logic v);
    return {1'b0, v, 5'h00, 6'h00, 5'h03};
  endfunction
  function automatic logic [17:0] bb(input logic v);
    return {1'b0, v, 16'h0};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if (out !== RST_V) $display("FAIL reset_out: got %h want %h", out, RST_V); else n_pass++;
    n_total++; if ({ea, gr} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {ea, gr}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (out !== gb(1)) $display("FAIL release_game: got %h want %h", out, gb(1)); else n_pass++;
    n_total++; if (out0 !== gb(1)) $display("FAIL release_game0: got %h want %h", out0, gb(1)); else n_pass++;
  endtask

  task automatic test_restart_in_game();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    n_total++; if ({out, ea, gr} !== {gb(1), 2'b00}) $display("FAIL restart_game: got %h want %h", {out, ea, gr}, {gb(1), 2'b00}); else n_pass++;
  endtask

  task automatic test_game_over();
    game_over = 1'b1;
    @(negedge clk);
    n_total++; if ({out, ea} !== {gb(1), 1'b0}) $display("FAIL to_end_wait: got %h want %h", {out, ea}, {gb(1), 1'b0}); else n_pass++;
    game_over = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (out !== gb(1)) $display("FAIL wait_frame: got %h want %h", out, gb(1)); else n_pass++;
    g_vs = 1'b0;
    @(negedge clk);
    n_total++; if ({out, ea} !== {gb(0), 1'b0}) $display("FAIL edge_cycle: got %h want %h", {out, ea}, {gb(0), 1'b0}); else n_pass++;
    n_total++; if (out0 !== gb(0)) $display("FAIL edge_cycle0: got %h want %h", out0, gb(0)); else n_pass++;
    g_vs = 1'b1;
    @(negedge clk);
    n_total++; if ({out, ea} !== {bb(1), 1'b0}) $display("FAIL blank_start: got %h want %h", {out, ea}, {bb(1), 1'b0}); else n_pass++;
    n_total++; if ({out0, ea0} !== {eb(1), 1'b1}) $display("FAIL zero_blank_end: got %h want %h", {out0, ea0}, {eb(1), 1'b1}); else n_pass++;
    e_vs = 1'b0;
    @(negedge clk);
    n_total++; if ({out, ea} !== {bb(0), 1'b0}) $display("FAIL blank_first_edge: got %h want %h", {out, ea}, {bb(0), 1'b0}); else n_pass++;
    e_vs = 1'b1;
    @(negedge clk);
    n_total++; if (out !== bb(1)) $display("FAIL blank_frame2: got %h want %h", out, bb(1)); else n_pass++;
    e_vs = 1'b0;
    @(negedge clk);
    n_total++; if ({out, ea} !== {bb(0), 1'b1}) $display("FAIL end_entry: got %h want %h", {out, ea}, {bb(0), 1'b1}); else n_pass++;
    e_vs = 1'b1;
    @(negedge clk);
    n_total++; if ({out, ea} !== {eb(1), 1'b1}) $display("FAIL end_colour: got %h want %h", {out, ea}, {eb(1), 1'b1}); else n_pass++;
    n_total++; if ({out0, ea0} !== {eb(1), 1'b1}) $display("FAIL end_colour0: got %h want %h", {out0, ea0}, {eb(1), 1'b1}); else n_pass++;
  endtask

  task automatic test_restart_end();
    restart = 1'b1;
    e_vs = 1'b0;
    @(negedge clk);
    n_total++; if ({out, ea, gr} !== {eb(0), 2'b00}) $display("FAIL restart_same_edge: got %h want %h", {out, ea, gr}, {eb(0), 2'b00}); else n_pass++;
    restart = 1'b0;
    @(negedge clk);
    e_vs = 1'b1;
    @(negedge clk);
    n_total++; if ({out, gr} !== {eb(1), 1'b0}) $display("FAIL to_game_wait: got %h want %h", {out, gr}, {eb(1), 1'b0}); else n_pass++;
    game_over = 1'b1;
    e_vs = 1'b0;
    @(negedge clk);
    n_total++; if ({out, gr} !== {eb(0), 1'b1}) $display("FAIL game_reset_pulse: got %h want %h", {out, gr}, {eb(0), 1'b1}); else n_pass++;
    n_total++; if (gr0 !== 1'b1) $display("FAIL game_reset_pulse0: got %b want 1", gr0); else n_pass++;
    e_vs = 1'b1;
    @(negedge clk);
    n_total++; if ({out, gr, ea} !== {gb(1), 2'b00}) $display("FAIL back_to_game: got %h want %h", {out, gr, ea}, {gb(1), 2'b00}); else n_pass++;
  endtask

  task automatic test_game_over_held();
    game_over = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (out !== gb(1)) $display("FAIL held_wait: got %h want %h", out, gb(1)); else n_pass++;
    g_vs = 1'b0;
    @(negedge clk);
    g_vs = 1'b1;
    @(negedge clk);
    n_total++; if (out !== bb(1)) $display("FAIL held_reblank: got %h want %h", out, bb(1)); else n_pass++;
  endtask

  task automatic test_async_reset();
    e_vs = 1'b0;
    @(negedge clk);
    e_vs = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    n_total++; if ({out, ea} !== {bb(1), 1'b0}) $display("FAIL restart_blank: got %h want %h", {out, ea}, {bb(1), 1'b0}); else n_pass++;
    restart = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if ({out, ea, gr} !== {RST_V, 2'b00}) $display("FAIL async_reset: got %h want %h", {out, ea, gr}, {RST_V, 2'b00}); else n_pass++;
    n_total++; if (out0 !== RST_V) $display("FAIL async_reset0: got %h want %h", out0, RST_V); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if ({out, ea} !== {gb(1), 1'b0}) $display("FAIL post_reset_game: got %h want %h", {out, ea}, {gb(1), 1'b0}); else n_pass++;
    e_vs = 1'b0;
    @(negedge clk);
    e_vs = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (out !== gb(1)) $display("FAIL no_pending_switch: got %h want %h", out, gb(1)); else n_pass++;
    n_total++; if (out0 !== gb(1)) $display("FAIL no_pending_switch0: got %h want %h", out0, gb(1)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_restart_in_game();
    test_game_over();
    test_restart_end();
    test_game_over_held();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
